// File: rtl/pes_cla_serial_adder.sv
// Multi-cycle WIDTH-bit adder built around one 4-bit carry-lookahead slice.
// One nibble is added per clock. The slice carry-out is registered between slices.
// Word-level propagate/generate are folded from the per-slice PG/GG terms.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst_n  - synchronous reset, active-low
//   start  - request, sampled only when not busy (IDLE or DONE)
//   a, b   - operands, captured on an accepted start
//   cin    - carry-in, captured on an accepted start
//   busy   - high while slices are being processed
//   done   - one-cycle pulse, sum/status valid
//   sum    - a+b+cin mod 2^WIDTH, held until the next accepted start
//   cout   - carry out of the MSB
//   pg     - word propagate (AND of all a^b bits)
//   gg     - word generate (carry out assuming cin=0)
//   ovf    - two's complement signed overflow
module pes_cla_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             pg,
  output logic             gg,
  output logic             ovf
);

  localparam int unsigned NumSlices = WIDTH / 4;
  localparam int unsigned KW        = (NumSlices > 1) ? $clog2(NumSlices) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [KW-1:0]    k_q, k_d;
  logic             carry_q, carry_d;
  logic             pg_acc_q, pg_acc_d;
  logic             gg_acc_q, gg_acc_d;
  logic             cout_q, cout_d;
  logic             pg_q, pg_d;
  logic             gg_q, gg_d;
  logic             ovf_q, ovf_d;

  // Current slice operands and lookahead terms.
  logic [3:0] a_sl, b_sl, p_sl, g_sl, s_sl;
  logic [4:0] c_sl;
  logic       sl_pg, sl_gg;
  logic       last_slice;

  always_comb begin
    a_sl = a_q[{k_q, 2'b00} +: 4];
    b_sl = b_q[{k_q, 2'b00} +: 4];
    p_sl = a_sl ^ b_sl;
    g_sl = a_sl & b_sl;

    sl_pg = &p_sl;
    sl_gg = g_sl[3]
          | (p_sl[3] & g_sl[2])
          | (p_sl[3] & p_sl[2] & g_sl[1])
          | (p_sl[3] & p_sl[2] & p_sl[1] & g_sl[0]);

    c_sl[0] = carry_q;
    c_sl[1] = g_sl[0] | (p_sl[0] & c_sl[0]);
    c_sl[2] = g_sl[1] | (p_sl[1] & g_sl[0]) | (p_sl[1] & p_sl[0] & c_sl[0]);
    c_sl[3] = g_sl[2]
            | (p_sl[2] & g_sl[1])
            | (p_sl[2] & p_sl[1] & g_sl[0])
            | (p_sl[2] & p_sl[1] & p_sl[0] & c_sl[0]);
    c_sl[4] = sl_gg | (sl_pg & c_sl[0]);

    s_sl = p_sl ^ c_sl[3:0];

    last_slice = (k_q == KW'(NumSlices - 1));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    k_d      = k_q;
    carry_d  = carry_q;
    pg_acc_d = pg_acc_q;
    gg_acc_d = gg_acc_q;
    cout_d   = cout_q;
    pg_d     = pg_q;
    gg_d     = gg_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StRun;
          a_d      = a;
          b_d      = b;
          k_d      = '0;
          carry_d  = cin;
          pg_acc_d = 1'b1;
          gg_acc_d = 1'b0;
          sum_d    = '0;
          cout_d   = 1'b0;
          pg_d     = 1'b0;
          gg_d     = 1'b0;
          ovf_d    = 1'b0;
        end else if (state_q == StDone) begin
          state_d = StIdle;
        end
      end

      StRun: begin
        // Replace only the nibble belonging to slice k.
        sum_d    = (sum_q & ~(WIDTH'(4'hF) << {k_q, 2'b00}))
                 | (WIDTH'(s_sl) << {k_q, 2'b00});
        carry_d  = c_sl[4];
        pg_acc_d = pg_acc_q & sl_pg;
        gg_acc_d = sl_gg | (sl_pg & gg_acc_q);
        k_d      = k_q + KW'(1);
        if (last_slice) begin
          state_d = StDone;
          k_d     = '0;
          cout_d  = c_sl[4];
          pg_d    = pg_acc_q & sl_pg;
          gg_d    = sl_gg | (sl_pg & gg_acc_q);
          // Carry into the MSB differs from carry out of it exactly on signed overflow.
          ovf_d   = c_sl[3] ^ c_sl[4];
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      k_q      <= '0;
      carry_q  <= 1'b0;
      pg_acc_q <= 1'b0;
      gg_acc_q <= 1'b0;
      cout_q   <= 1'b0;
      pg_q     <= 1'b0;
      gg_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      k_q      <= k_d;
      carry_q  <= carry_d;
      pg_acc_q <= pg_acc_d;
      gg_acc_q <= gg_acc_d;
      cout_q   <= cout_d;
      pg_q     <= pg_d;
      gg_q     <= gg_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign pg   = pg_q;
  assign gg   = gg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pes_cla_serial_adder.sv
// Directed and random checks of pes_cla_serial_adder (WIDTH=16) against an arithmetic model.
module tb_pes_cla_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout, pg, gg, ovf;

  int total = 0;
  int bad   = 0;

  pes_cla_serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .pg   (pg),
    .gg   (gg),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the accepting edge until done is seen (bounded).
  task automatic run_wait(input int lat0, output int lat);
    lat = lat0;
    while (done !== 1'b1 && lat <= N + 3) begin
      chk("busy_run", {31'b0, busy}, 32'd1);
      step();
      lat++;
    end
  endtask

  // Reference: plain integer addition.
  task automatic check_res(input string tag, input logic [W-1:0] ea, input logic [W-1:0] eb,
                           input logic ec);
    logic [W:0] full, nocin;
    logic       e_ovf;
    full  = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
    nocin = {1'b0, ea} + {1'b0, eb};
    e_ovf = (ea[W-1] == eb[W-1]) && (full[W-1] != ea[W-1]);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_sum"},  {16'b0, sum}, {16'b0, full[W-1:0]});
    chk({tag, "_cout"}, {31'b0, cout}, {31'b0, full[W]});
    chk({tag, "_pg"},   {31'b0, pg}, {31'b0, &(ea ^ eb)});
    chk({tag, "_gg"},   {31'b0, gg}, {31'b0, nocin[W]});
    chk({tag, "_ovf"},  {31'b0, ovf}, {31'b0, e_ovf});
  endtask

  // Drive a request for one edge, then scramble the pins while the op runs.
  task automatic start_op(input logic [W-1:0] sa, input logic [W-1:0] sb, input logic sc);
    a = sa; b = sb; cin = sc; start = 1'b1;
    step();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] sa, input logic [W-1:0] sb,
                       input logic sc);
    int lat;
    start_op(sa, sb, sc);
    run_wait(0, lat);
    chk({tag, "_lat"}, lat, N);
    check_res(tag, sa, sb, sc);
  endtask

  initial begin
    int lat, lat2, dones;
    logic [W-1:0] ra, rb;
    logic rc;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    step(); step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_flags", {28'b0, cout, pg, gg, ovf}, 32'd0);
    rst_n = 1'b1;
    step();

    // Test 1: with accept-edge checks on cleared status.
    a = 16'h0001; b = 16'h0000; cin = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy_e0", {31'b0, busy}, 32'd1);
    chk("t1_clear", {16'b0, sum}, 32'd0);
    run_wait(0, lat);
    chk("t1_lat", lat, N);
    check_res("t1", 16'h0001, 16'h0000, 1'b0);
    step();
    chk("t1_idle_done", {31'b0, done}, 32'd0);
    chk("t1_hold_sum", {16'b0, sum}, 32'h0001);

    do_op("t2", 16'hFFFF, 16'h0001, 1'b0);
    step();
    chk("t2_hold_gg", {31'b0, gg}, 32'd1);
    do_op("t3", 16'h5555, 16'hAAAA, 1'b1);
    step();
    do_op("t4a", 16'h7FFF, 16'h0001, 1'b0);
    step();
    do_op("t4b", 16'h8000, 16'h8000, 1'b0);
    step();

    // Test 5a: start pulsed at edge 2 of a run is ignored.
    start_op(16'h1111, 16'h2222, 1'b0);
    step();
    a = 16'hABCD; b = 16'hDCBA; cin = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    run_wait(2, lat);
    chk("t5_lat", lat, N);
    check_res("t5", 16'h1111, 16'h2222, 1'b0);
    step();

    // Test 5b: reset at edge 2 of a run aborts it without a done pulse.
    start_op(16'hFFFF, 16'hFFFF, 1'b1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5r_busy", {31'b0, busy}, 32'd0);
    chk("t5r_done", {31'b0, done}, 32'd0);
    chk("t5r_sum", {16'b0, sum}, 32'd0);
    chk("t5r_flags", {28'b0, cout, pg, gg, ovf}, 32'd0);
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done === 1'b1) dones++;
    end
    chk("t5r_no_done", dones, 0);

    // Test 6: start held through DONE; four busy cycles separate the two done pulses.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    step();
    run_wait(0, lat);
    chk("t6_lat1", lat, N);
    check_res("t6a", 16'h1234, 16'h4321, 1'b0);
    step();
    chk("t6_restart_busy", {31'b0, busy}, 32'd1);
    chk("t6_restart_done", {31'b0, done}, 32'd0);
    run_wait(0, lat2);
    start = 1'b0;
    chk("t6_gap", lat + lat2 + 1, 2 * N + 1);
    check_res("t6b", 16'h1234, 16'h4321, 1'b0);
    chk("t6_sum", {16'b0, sum}, 32'h5555);

    // Random vectors, sometimes restarting straight from the DONE cycle.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rb = ~ra;
      do_op("rnd", ra, rb, rc);
      if ($urandom_range(0, 1) == 1) step();
    end

    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
